vram_line_fetcher: RTL and testbench

- Upstream read-side feeder for the dual-port video/shadow RAM; drives that RAM's read port (one-cycle registered read latency).
- On each `start`, fetches LINE_LEN consecutive words beginning at `base_addr` and buffers them in an internal FIFO.
- The FIFO is drained by the pixel/scanline consumer through a valid/ready handshake.
- Decouples RAM read timing from video output timing.

---
 rtl/vram_line_fetcher.sv | 157 +++++++++++++++
 tb/tb_vram_line_fetcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_line_fetcher.sv
// Line fetcher: reads LINE_LEN consecutive words from the video RAM read port into a small FIFO drained by a valid/ready consumer.
// Optional underrun statistic enabled by defining LINE_FETCH_UNDERRUN_EN.
module vram_line_fetcher #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 8,
    parameter int unsigned LINE_LEN  = 40,
    parameter int unsigned FIFO_LOG2 = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [15:0]   underrun_cnt
);

    localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
    localparam int unsigned CW    = $clog2(LINE_LEN + 1);
    localparam int unsigned OW    = FIFO_LOG2 + 1;

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         pushed_q, pushed_d;
    logic                  inflight_q, inflight_d;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]         count_q;

    logic                  push, pop, room, last_push;
    logic [OW-1:0]         free_slots;

    assign push       = inflight_q;
    assign pix_valid  = (count_q != '0);
    assign pop        = pix_valid && pix_ready;
    assign pix_data   = pix_valid ? mem_q[rd_ptr_q] : '0;
    assign free_slots = OW'(DEPTH) - count_q;

    // A read may issue only if a slot is still unreserved after the outstanding read lands.
    assign room      = ({1'b0, free_slots} + (OW + 1)'(pop)) > (OW + 1)'(inflight_q);
    assign last_push = inflight_q && (pushed_q == CW'(LINE_LEN - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            pushed_q   <= pushed_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        pushed_d   = pushed_q;
        inflight_d = ram_rd;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    issued_d = '0;
                    pushed_d = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ram_rd) begin
                    addr_d   = addr_q + AW'(1);
                    issued_d = issued_q + CW'(1);
                end
                if (inflight_q) begin
                    pushed_d = pushed_q + CW'(1);
                end
                if (last_push) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_rd   = 1'b0;
        ram_addr = addr_q;
        if (state_q == S_FETCH) begin
            busy   = 1'b1;
            done   = last_push;
            ram_rd = (issued_q != CW'(LINE_LEN)) && room;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ram_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + OW'(1);
                2'b01:   count_q <= count_q - OW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef LINE_FETCH_UNDERRUN_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
        end else if (busy && pix_ready && !pix_valid && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Directed bench: a 4-word-line instance (basic, wrap, done/start overlap, underrun) and a 40-word-line instance (backpressure, start-while-busy, reset).
module tb_vram_line_fetcher;

    logic        clk = 1'b0;
    logic        reset;

    logic        start_a, busy_a, done_a, rd_a, valid_a, ready_a;
    logic [9:0]  base_a, addr_a;
    logic [7:0]  q_a, data_a;
    logic [15:0] und_a;

    logic        start_b, busy_b, done_b, rd_b, valid_b, ready_b;
    logic [9:0]  base_b, addr_b;
    logic [7:0]  q_b, data_b;
    logic [15:0] und_b;

    logic [7:0]  ram [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_line_fetcher #(.AW(10), .DW(8), .LINE_LEN(4), .FIFO_LOG2(3)) dut_a (
        .clk_sys(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .busy(busy_a), .done(done_a), .ram_addr(addr_a), .ram_rd(rd_a),
        .ram_q(q_a), .pix_data(data_a), .pix_valid(valid_a), .pix_ready(ready_a),
        .underrun_cnt(und_a)
    );

    vram_line_fetcher #(.AW(10), .DW(8), .LINE_LEN(40), .FIFO_LOG2(3)) dut_b (
        .clk_sys(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .busy(busy_b), .done(done_b), .ram_addr(addr_b), .ram_rd(rd_b),
        .ram_q(q_b), .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
        .underrun_cnt(und_b)
    );

    // Registered-read RAM model, one read port per instance.
    always @(posedge clk) begin
        if (rd_a) q_a <= ram[addr_a];
        if (rd_b) q_b <= ram[addr_b];
    end

    // RAM contents: word at address a is (a - 16) mod 256, so 0x020..0x023 hold 0x10..0x13.
    function automatic logic [7:0] ew(input int a);
        return 8'((a % 1024) - 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain_b(input int base, input int n, output int got, output int dones);
        got   = 0;
        dones = 0;
        ready_b = 1'b1;
        for (int c = 0; c < 400 && got < n; c++) begin
            if (done_b) dones++;
            if (valid_b) begin
                chk("drain_word", data_b, ew(base + got));
                got++;
            end
            step();
        end
    endtask

    initial begin
        int reads, dn, got, dones, seen;

        for (int i = 0; i < 1024; i++) ram[i] = ew(i);
        reset   = 1'b1;
        start_a = 1'b0; base_a = '0; ready_a = 1'b1;
        start_b = 1'b0; base_b = '0; ready_b = 1'b0;
        step();
        step();

        chk("rst_busy",  busy_a,  0);
        chk("rst_done",  done_a,  0);
        chk("rst_rd",    rd_a,    0);
        chk("rst_addr",  addr_a,  0);
        chk("rst_valid", valid_a, 0);
        chk("rst_data",  data_a,  0);
        chk("rst_und",   und_a,   0);
        reset = 1'b0;
        step();

        // Basic 4-word line from 0x020.
        base_a = 10'h020; start_a = 1'b1;
        step();                               // T+1
        start_a = 1'b0;
        chk("t1_busy1",  busy_a,  1);
        chk("t1_rd1",    rd_a,    1);
        chk("t1_addr1",  addr_a,  10'h020);
        chk("t1_valid1", valid_a, 0);
        step();                               // T+2
        chk("t1_addr2",  addr_a,  10'h021);
        chk("t1_valid2", valid_a, 0);
        step();                               // T+3
        chk("t1_rd3",    rd_a,    1);
        chk("t1_valid3", valid_a, 1);
        chk("t1_data3",  data_a,  8'h10);
        step();                               // T+4
        chk("t1_addr4",  addr_a,  10'h023);
        chk("t1_data4",  data_a,  8'h11);
        chk("t1_done4",  done_a,  0);
        step();                               // T+5
        chk("t1_rd5",    rd_a,    0);
        chk("t1_done5",  done_a,  1);
        chk("t1_busy5",  busy_a,  1);
        chk("t1_data5",  data_a,  8'h12);
        step();                               // T+6
        chk("t1_busy6",  busy_a,  0);
        chk("t1_done6",  done_a,  0);
        chk("t1_data6",  data_a,  8'h13);
        step();                               // T+7
        chk("t1_valid7", valid_a, 0);

        // Address wrap from 0x3FE, then a start coinciding with done.
        base_a = 10'h3FE; start_a = 1'b1;
        step();                               // T+1
        start_a = 1'b0;
        chk("wrap_a0", addr_a, 10'h3FE);
        step();
        chk("wrap_a1", addr_a, 10'h3FF);
        step();
        chk("wrap_a2", addr_a, 10'h000);
        chk("wrap_d0", data_a, 8'hEE);
        step();
        chk("wrap_a3", addr_a, 10'h001);
        chk("wrap_rd3", rd_a, 1);
        chk("wrap_d1", data_a, 8'hEF);
        step();                               // T+5
        chk("wrap_done", done_a, 1);
        chk("wrap_d2", data_a, 8'hF0);
        base_a = 10'h300; start_a = 1'b1;
        step();                               // T+6: start during done was ignored
        chk("ovl_busy", busy_a, 0);
        chk("ovl_rd",   rd_a,   0);
        chk("wrap_d3",  data_a, 8'hF1);
        step();                               // T+7: start held, now accepted
        start_a = 1'b0;
        chk("ovl_busy2", busy_a, 1);
        chk("ovl_addr2", addr_a, 10'h300);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (done_a) seen = 1;
            step();
        end
        chk("ovl_done_seen", seen, 1);
        repeat (3) step();

        // Backpressure on the 40-word instance.
        ready_b = 1'b0; base_b = 10'h080; start_b = 1'b1;
        step();
        start_b = 1'b0;
        reads = 0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_b) reads++;
            if (done_b) dn++;
            step();
        end
        chk("bp_reads",   reads,   8);
        chk("bp_rd_low",  rd_b,    0);
        chk("bp_no_done", dn,      0);
        chk("bp_busy",    busy_b,  1);
        chk("bp_valid",   valid_b, 1);
        chk("bp_head",    data_b,  8'h70);
        drain_b(10'h080, 40, got, dones);
        chk("bp_words", got,   40);
        chk("bp_dones", dones, 1);
        step();
        chk("bp_valid_end", valid_b, 0);
        chk("bp_busy_end",  busy_b,  0);

        // Start while busy is ignored.
        ready_b = 1'b0; base_b = 10'h200; start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (4) step();
        base_b = 10'h100; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("sb_busy", busy_b, 1);
        chk("sb_addr", addr_b, 10'h205);
        drain_b(10'h200, 40, got, dones);
        chk("sb_words", got,   40);
        chk("sb_dones", dones, 1);
        repeat (2) step();

        // Reset mid-line after 3 reads.
        ready_b = 1'b0; base_b = 10'h000; start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (3) step();
        chk("rm_valid_pre", valid_b, 1);
        reset = 1'b1;
        #1;
        chk("rm_busy",  busy_b,  0);
        chk("rm_valid", valid_b, 0);
        chk("rm_rd",    rd_b,    0);
        step();
        chk("rm_und_b", und_b, 0);
        step();
        reset = 1'b0;
        base_b = 10'h050; start_b = 1'b1;
        step();
        start_b = 1'b0;
        drain_b(10'h050, 40, got, dones);
        chk("rm_words", got,   40);
        chk("rm_dones", dones, 1);

        // Underrun statistic over a 4-word line with ready held high.
        ready_a = 1'b1; base_a = 10'h020; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (8) step();
`ifdef LINE_FETCH_UNDERRUN_EN
        chk("und_cnt", und_a, 2);
`else
        chk("und_cnt", und_a, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
